sonic_vc_tx_fifo_p0_adapter: RTL and testbench



---
 rtl/sonic_vc_pkg.sv | 17 +
 rtl/sonic_vc_skid_ram.sv | 26 ++
 rtl/sonic_vc_tx_fifo_p0_adapter.sv | 88 ++++++++
 tb/tb_sonic_vc_tx_fifo_p0_adapter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sonic_vc_pkg.sv
// sonic_vc_pkg: shared widths and sizing helpers for the VC TX adapter slice
//   VC_DATA_W / VC_EMPTY_W / VC_DEPTH : default data, empty and skid depth
//   payload_w()  : packed {data, sop, eop, empty} width
//   ptr_w()      : skid FIFO pointer width, clog2 of depth
package sonic_vc_pkg;
    localparam int VC_DATA_W  = 128;
    localparam int VC_EMPTY_W = 2;
    localparam int VC_DEPTH   = 4;
    function automatic int payload_w(input int data_w, input int empty_w);
        return data_w + empty_w + 2;
    endfunction
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    localparam int VC_PAYLOAD_W = payload_w(VC_DATA_W, VC_EMPTY_W);
    localparam int VC_PTR_W     = ptr_w(VC_DEPTH);
endpackage

// File: rtl/sonic_vc_skid_ram.sv
// sonic_vc_skid_ram: DEPTH x W register array, one write port, combinational read port
//   clk   in  clock
//   we    in  write enable, stores wdata at waddr on the rising edge
//   waddr in  write address
//   wdata in  write payload
//   raddr in  read address
//   rdata out payload at raddr (combinational, no reset)
module sonic_vc_skid_ram
    import sonic_vc_pkg::*;
#(
    parameter int DEPTH = VC_DEPTH,
    parameter int W     = VC_PAYLOAD_W,
    localparam int AW   = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/sonic_vc_tx_fifo_p0_adapter.sv
// sonic_vc_tx_fifo_p0_adapter: Avalon-ST ready-latency 1 -> 0 adapter with skid FIFO
//   clk, reset_n          clock, async active-low reset
//   in_ready              registered; high in cycle t permits one beat in cycle t+1
//   in_valid/in_*         upstream beat {data, sop, eop, empty}
//   out_ready             downstream ready (latency 0)
//   out_valid/out_*       FIFO head, valid whenever the FIFO is not empty
//   overflow_err          sticky dropped-beat flag, built only with
//                         SONIC_VC_TX_ADAPTER_OVF_CHECK_EN, otherwise tied 0
module sonic_vc_tx_fifo_p0_adapter
    import sonic_vc_pkg::*;
#(
    parameter int DATA_W  = VC_DATA_W,
    parameter int EMPTY_W = VC_EMPTY_W,
    parameter int DEPTH   = VC_DEPTH
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               in_ready,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               overflow_err
);
    localparam int PW = payload_w(DATA_W, EMPTY_W);
    localparam int AW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic          acc_q;
    logic          wr;
    logic          rd;
    logic          in_ready_d;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [PW-1:0] head;
    // explicit wrap keeps non-power-of-2 depths correct
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction
    assign wr        = in_valid && acc_q;
    assign out_valid = count != '0;
    assign rd        = out_valid && out_ready;
    assign count_nxt = count + CW'(wr) - CW'(rd);
    // credit counts the beat that may still land next cycle for the current in_ready
    assign in_ready_d = ({1'b0, count_nxt} + (CW+1)'(in_ready)) < (CW+1)'(DEPTH);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            in_ready <= 1'b0;
            acc_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            in_ready <= in_ready_d;
            acc_q    <= in_ready;
            wr_ptr   <= wr ? inc(wr_ptr) : wr_ptr;
            rd_ptr   <= rd ? inc(rd_ptr) : rd_ptr;
            count    <= count_nxt;
        end
    sonic_vc_skid_ram #(.DEPTH(DEPTH), .W(PW)) u_ram (
        .clk   (clk),
        .we    (wr),
        .waddr (wr_ptr),
        .wdata ({in_data, in_startofpacket, in_endofpacket, in_empty}),
        .raddr (rd_ptr),
        .rdata (head)
    );
    assign {out_data, out_startofpacket, out_endofpacket, out_empty} = head;
`ifdef SONIC_VC_TX_ADAPTER_OVF_CHECK_EN
    logic drop;
    assign drop = in_valid && !acc_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) overflow_err <= 1'b0;
        else if (drop) overflow_err <= 1'b1;
    a_no_drop: assert property (@(posedge clk) disable iff (!reset_n) !drop);
    a_no_ovf: assert property (@(posedge clk) disable iff (!reset_n) !(wr && count == CW'(DEPTH)));
`else
    assign overflow_err = 1'b0;
`endif
endmodule

// File: tb/tb_sonic_vc_tx_fifo_p0_adapter.sv
// tb_sonic_vc_tx_fifo_p0_adapter: directed table plus sequence bench with a scoreboard queue
`timescale 1ns/1ps
module tb_sonic_vc_tx_fifo_p0_adapter;
    localparam int DW    = 128;
    localparam int EW    = 2;
    localparam int PW    = DW + EW + 2;
    localparam int DEPTH = 4;
`ifdef SONIC_VC_TX_ADAPTER_OVF_CHECK_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_ready;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_startofpacket;
    logic          in_endofpacket;
    logic [EW-1:0] in_empty;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_startofpacket;
    logic          out_endofpacket;
    logic [EW-1:0] out_empty;
    logic          overflow_err;
    always #5 clk = ~clk;
    sonic_vc_tx_fifo_p0_adapter #(.DATA_W(DW), .EMPTY_W(EW), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .overflow_err      (overflow_err)
    );
    int            checks = 0;
    int            errors = 0;
    int            nrx = 0;
    logic [PW-1:0] q[$];
    logic          rdy_last;
    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ord;
        logic       rdy;
        logic       ov;
        logic [7:0] hd;
    } vec_t;
    vec_t tbl[13];
    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [PW-1:0] mk(input logic [15:0] d, input logic sop, input logic eop, input logic [EW-1:0] e);
        return {DW'(d), sop, eop, e};
    endfunction
    // one clock cycle: drive, check the head against the scoreboard, record handshakes
    task automatic cyc(input logic iv, input logic [PW-1:0] p, input logic ord);
        in_valid = iv;
        {in_data, in_startofpacket, in_endofpacket, in_empty} = p;
        out_ready = ord;
        #1;
        chk("out_valid", PW'(out_valid), PW'(q.size() != 0));
        if (out_valid && out_ready && q.size() != 0) begin
            chk("head", {out_data, out_startofpacket, out_endofpacket, out_empty}, q.pop_front());
            nrx++;
        end
        if (iv && rdy_last) q.push_back(p);
        chk("occupancy_le_depth", PW'(q.size() > DEPTH), '0);
        rdy_last = in_ready;
        @(posedge clk);
        #1;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1);
    end
    initial begin
        int start;
        int sent;
        tbl[0]  = '{0, 8'h00, 0, 0, 0, 8'h00};
        tbl[1]  = '{0, 8'h00, 0, 1, 0, 8'h00};
        tbl[2]  = '{1, 8'hA0, 0, 1, 0, 8'h00};
        tbl[3]  = '{1, 8'hA1, 0, 1, 1, 8'hA0};
        tbl[4]  = '{1, 8'hA2, 0, 1, 1, 8'hA0};
        tbl[5]  = '{1, 8'hA3, 0, 0, 1, 8'hA0};
        tbl[6]  = '{0, 8'h00, 0, 0, 1, 8'hA0};
        tbl[7]  = '{0, 8'h00, 0, 0, 1, 8'hA0};
        tbl[8]  = '{0, 8'h00, 1, 0, 1, 8'hA0};
        tbl[9]  = '{0, 8'h00, 1, 1, 1, 8'hA1};
        tbl[10] = '{0, 8'h00, 1, 1, 1, 8'hA2};
        tbl[11] = '{0, 8'h00, 1, 1, 1, 8'hA3};
        tbl[12] = '{0, 8'h00, 1, 1, 0, 8'h00};
        reset_n = 1'b0;
        in_valid = 1'b1;
        in_data = '0;
        in_startofpacket = 1'b0;
        in_endofpacket = 1'b0;
        in_empty = '0;
        out_ready = 1'b0;
        rdy_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("rst_in_ready", PW'(in_ready), '0);
            chk("rst_out_valid", PW'(out_valid), '0);
            chk("rst_overflow_err", PW'(overflow_err), '0);
        end
        in_valid = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = tbl[i].iv;
            in_data = DW'(tbl[i].d);
            out_ready = tbl[i].ord;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), PW'(in_ready), PW'(tbl[i].rdy));
            chk($sformatf("tbl%0d_out_valid", i), PW'(out_valid), PW'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("tbl%0d_out_data", i), PW'(out_data), PW'(tbl[i].hd));
            rdy_last = in_ready;
            @(posedge clk);
            #1;
        end
        start = nrx;
        for (int i = 0; i < 33; i++) begin
            cyc(i < 32, mk(16'(i), i == 0, i == 31, (i == 31) ? 2'd2 : 2'd0), 1'b1);
            chk($sformatf("stream_in_ready%0d", i), PW'(in_ready), PW'(1));
        end
        chk("stream_beats", PW'(nrx - start), PW'(32));
        chk("stream_drained", PW'(q.size()), '0);
        start = nrx;
        sent = 0;
        for (int c = 0; c < 6000 && (sent < 1000 || q.size() != 0); c++) begin
            logic v;
            v = rdy_last && sent < 1000;
            cyc(v, mk(16'(sent), sent % 8 == 0, sent % 8 == 7, 2'(sent)), 1'($urandom_range(0, 1)));
            if (v) sent++;
        end
        chk("random_beats", PW'(nrx - start), PW'(1000));
        chk("random_drained", PW'(q.size()), '0);
        chk("random_overflow_err", PW'(overflow_err), '0);
        for (int i = 0; i < 10 && rdy_last; i++) cyc(1'b1, mk(16'(16'h100 + i), 0, 0, 0), 1'b0);
        cyc(1'b1, mk(16'hBAD, 1, 1, 3), 1'b0);
        chk("viol_overflow_err", PW'(overflow_err), PW'(OVF_EN));
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
        chk("viol_drained", PW'(q.size()), '0);
        chk("viol_sticky", PW'(overflow_err), PW'(OVF_EN));
        for (int i = 0; i < 3; i++) cyc(rdy_last, mk(16'(16'h300 + i), 0, 0, 0), 1'b0);
        cyc(1'b0, '0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", PW'(out_valid), '0);
        chk("midrst_in_ready", PW'(in_ready), '0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        rdy_last = 1'b0;
        chk("midrst_overflow_clr", PW'(overflow_err), '0);
        cyc(1'b0, '0, 1'b1);
        chk("midrst_ready_rise", PW'(in_ready), PW'(1));
        start = nrx;
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, mk(16'h5A5, 1, 1, 1), 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        chk("midrst_new_beat", PW'(nrx - start), PW'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
